// File: rtl/cpu_6502_if.sv
// Memory bus between the cpu_6502 core and main RAM: address, read data, write data, write enable.
// The core samples di at the rising edge that ends each bus cycle.
interface cpu_6502_if;
    logic [15:0] ab;
    logic [7:0]  di;
    logic [7:0]  dout;
    logic        we;

    modport master (output ab, output dout, output we, input di);
    modport slave  (input ab, input dout, input we, output di);
endinterface

// File: rtl/cpu_6502.sv
// Minimal 6502 core: LDA/LDX/LDY/STA/STX/STY in immediate, zero-page and absolute modes.
// States:  T0 | opcode fetch    T1 | operand fetch    T2 | address high byte    EX | data access at EA
module cpu_6502 (
    input  logic       clk,
    input  logic       reset,
    cpu_6502_if.master bus
);
    typedef enum logic [1:0] {T0, T1, T2, EX} state_t;
    typedef enum logic [1:0] {M_IMM, M_ZP, M_ABS, M_UND} mode_t;

    localparam logic [1:0] R_A = 2'd0;
    localparam logic [1:0] R_X = 2'd1;
    localparam logic [1:0] R_Y = 2'd2;

    state_t      state;
    mode_t       mode;
    logic        is_store;
    logic [1:0]  rsel;
    logic [7:0]  src;
    logic        load_en;
    logic [7:0]  a, x, y, ir, ea_lo;
    logic [15:0] pc, pc_inc;
    logic        flag_n, flag_z;

    assign pc_inc = pc + 16'd1;

    always_comb begin
        mode     = M_UND;
        is_store = 1'b0;
        rsel     = R_A;
        case (ir)
            8'hA9: begin mode = M_IMM; rsel = R_A; end
            8'hA2: begin mode = M_IMM; rsel = R_X; end
            8'hA0: begin mode = M_IMM; rsel = R_Y; end
            8'hA5: begin mode = M_ZP;  rsel = R_A; end
            8'hA6: begin mode = M_ZP;  rsel = R_X; end
            8'hA4: begin mode = M_ZP;  rsel = R_Y; end
            8'hAD: begin mode = M_ABS; rsel = R_A; end
            8'hAE: begin mode = M_ABS; rsel = R_X; end
            8'hAC: begin mode = M_ABS; rsel = R_Y; end
            8'h85: begin mode = M_ZP;  rsel = R_A; is_store = 1'b1; end
            8'h86: begin mode = M_ZP;  rsel = R_X; is_store = 1'b1; end
            8'h84: begin mode = M_ZP;  rsel = R_Y; is_store = 1'b1; end
            8'h8D: begin mode = M_ABS; rsel = R_A; is_store = 1'b1; end
            8'h8E: begin mode = M_ABS; rsel = R_X; is_store = 1'b1; end
            8'h8C: begin mode = M_ABS; rsel = R_Y; is_store = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        case (rsel)
            R_X:     src = x;
            R_Y:     src = y;
            default: src = a;
        endcase
    end

    // Both load paths take their value from di: the operand in T1, the memory byte in EX.
    assign load_en = (state == T1 && mode == M_IMM) || (state == EX && !is_store);

    // ab always holds the address of the cycle in progress, so in EX it is the full EA.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= T0;
            pc       <= 16'h0000;
            a        <= 8'h00;
            x        <= 8'h00;
            y        <= 8'h00;
            ir       <= 8'h00;
            ea_lo    <= 8'h00;
            flag_n   <= 1'b0;
            flag_z   <= 1'b0;
            bus.ab   <= 16'h0000;
            bus.we   <= 1'b0;
            bus.dout <= 8'h00;
        end else begin
            bus.we <= 1'b0;
            if (load_en) begin
                case (rsel)
                    R_X:     x <= bus.di;
                    R_Y:     y <= bus.di;
                    default: a <= bus.di;
                endcase
                flag_z <= (bus.di == 8'h00);
                flag_n <= bus.di[7];
            end
            case (state)
                T0: begin
                    ir     <= bus.di;
                    pc     <= pc_inc;
                    bus.ab <= pc_inc;
                    state  <= T1;
                end
                T1: begin
                    case (mode)
                        M_IMM: begin
                            pc     <= pc_inc;
                            bus.ab <= pc_inc;
                            state  <= T0;
                        end
                        M_ZP: begin
                            pc     <= pc_inc;
                            bus.ab <= {8'h00, bus.di};
                            state  <= EX;
                            if (is_store) begin
                                bus.we   <= 1'b1;
                                bus.dout <= src;
                            end
                        end
                        M_ABS: begin
                            ea_lo  <= bus.di;
                            pc     <= pc_inc;
                            bus.ab <= pc_inc;
                            state  <= T2;
                        end
                        default: begin
                            bus.ab <= pc;
                            state  <= T0;
                        end
                    endcase
                end
                T2: begin
                    pc     <= pc_inc;
                    bus.ab <= {bus.di, ea_lo};
                    state  <= EX;
                    if (is_store) begin
                        bus.we   <= 1'b1;
                        bus.dout <= src;
                    end
                end
                default: begin
                    bus.ab <= pc;
                    state  <= T0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_6502.sv
// Bench for cpu_6502: an instruction-level model predicts every bus cycle and the
// architectural registers at instruction boundaries; directed programs add literal checks.
module tb_cpu_6502;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic chk_en = 1'b0;

    cpu_6502_if bus ();
    cpu_6502 dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    logic [7:0] mem [0:65535];
    assign bus.di = mem[bus.ab];
    always @(posedge clk) if (bus.we) mem[bus.ab] = bus.dout;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Instruction-level model
    typedef struct packed {
        logic [15:0] ab;
        logic        we;
        logic [7:0]  d;
    } cyc_t;
    typedef logic [7:0] byte_q_t [$];

    logic [7:0]  mm [0:65535];
    logic [15:0] m_pc;
    logic [7:0]  m_a, m_x, m_y;
    logic        m_n, m_z;
    cyc_t        q [$];

    task automatic push(input logic [15:0] ab, input logic we, input logic [7:0] d);
        cyc_t c;
        c.ab = ab; c.we = we; c.d = d;
        q.push_back(c);
    endtask

    task automatic set_reg(input int r, input logic [7:0] v);
        if (r == 0) m_a = v; else if (r == 1) m_x = v; else m_y = v;
        m_z = (v == 8'h00);
        m_n = v[7];
    endtask

    task automatic model_step();
        logic [7:0]  op, opnd, v;
        logic [15:0] ea;
        int kind, r;
        bit st;
        op = mm[m_pc];
        push(m_pc, 1'b0, 8'h00);
        m_pc++;
        kind = 0; r = 0; st = 0;
        case (op)
            8'hA9: begin kind = 1; r = 0; end
            8'hA2: begin kind = 1; r = 1; end
            8'hA0: begin kind = 1; r = 2; end
            8'hA5: begin kind = 2; r = 0; end
            8'hA6: begin kind = 2; r = 1; end
            8'hA4: begin kind = 2; r = 2; end
            8'hAD: begin kind = 3; r = 0; end
            8'hAE: begin kind = 3; r = 1; end
            8'hAC: begin kind = 3; r = 2; end
            8'h85: begin kind = 2; r = 0; st = 1; end
            8'h86: begin kind = 2; r = 1; st = 1; end
            8'h84: begin kind = 2; r = 2; st = 1; end
            8'h8D: begin kind = 3; r = 0; st = 1; end
            8'h8E: begin kind = 3; r = 1; st = 1; end
            8'h8C: begin kind = 3; r = 2; st = 1; end
            default: kind = 0;
        endcase
        push(m_pc, 1'b0, 8'h00);
        opnd = mm[m_pc];
        if (kind == 0) return;
        m_pc++;
        if (kind == 1) begin
            set_reg(r, opnd);
            return;
        end
        ea = {8'h00, opnd};
        if (kind == 3) begin
            push(m_pc, 1'b0, 8'h00);
            ea[15:8] = mm[m_pc];
            m_pc++;
        end
        if (st) begin
            v = (r == 0) ? m_a : (r == 1) ? m_x : m_y;
            push(ea, 1'b1, v);
            mm[ea] = v;
        end else begin
            push(ea, 1'b0, 8'h00);
            set_reg(r, mm[ea]);
        end
    endtask

    task automatic check_regs(input string tag);
        chk({tag, "_a"}, 32'(dut.a), 32'(m_a));
        chk({tag, "_x"}, 32'(dut.x), 32'(m_x));
        chk({tag, "_y"}, 32'(dut.y), 32'(m_y));
        chk({tag, "_n"}, 32'(dut.flag_n), 32'(m_n));
        chk({tag, "_z"}, 32'(dut.flag_z), 32'(m_z));
    endtask

    logic [15:0] hist [0:63];
    int hist_n = 0;
    int we_cnt = 0;

    always @(negedge clk) begin : compare
        cyc_t e;
        if (chk_en) begin
            if (q.size() == 0) begin
                check_regs("boundary");
                model_step();
            end
            e = q.pop_front();
            chk("ab", 32'(bus.ab), 32'(e.ab));
            chk("we", 32'(bus.we), 32'(e.we));
            if (e.we) chk("do", 32'(bus.dout), 32'(e.d));
            if (hist_n < 64) begin
                hist[hist_n] = bus.ab;
                hist_n++;
            end
            if (bus.we) we_cnt++;
        end
    end

    task automatic hold_reset();
        chk_en = 1'b0;
        reset  = 1'b0;
        #1;
        for (int i = 0; i < 65536; i++) begin
            mem[i] = 8'h00;
            mm[i]  = 8'h00;
        end
    endtask

    task automatic poke(input logic [15:0] addr, input logic [7:0] v);
        mem[addr] = v;
        mm[addr]  = v;
    endtask

    task automatic load_prog(input byte_q_t p);
        for (int i = 0; i < p.size(); i++) poke(16'(i), p[i]);
    endtask

    task automatic go();
        m_pc = 16'h0000;
        m_a = 8'h00; m_x = 8'h00; m_y = 8'h00;
        m_n = 1'b0;  m_z = 1'b0;
        q.delete();
        hist_n = 0;
        we_cnt = 0;
        @(posedge clk);
        #1;
        reset  = 1'b1;
        chk_en = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic end_check(input string tag);
        check_regs(tag);
        chk({tag, "_drained"}, 32'(q.size()), 32'd0);
    endtask

    byte_q_t prog;

    initial begin
        // Reset state
        hold_reset();
        chk("rst_ab", 32'(bus.ab), 32'h0000);
        chk("rst_we", 32'(bus.we), 32'h0);
        chk("rst_do", 32'(bus.dout), 32'h00);
        chk("rst_a", 32'(dut.a), 32'h00);

        // Absolute and zero-page load/store
        hold_reset();
        poke(16'h0030, 8'h71);
        poke(16'h0400, 8'h90);
        prog = '{8'hAE, 8'h00, 8'h04, 8'h8E, 8'h40, 8'h04, 8'hA5, 8'h30, 8'h85, 8'h35};
        load_prog(prog);
        go();
        run(14);
        end_check("t1");
        chk("t1_mem0440", 32'(mem[16'h0440]), 32'h90);
        chk("t1_mem0035", 32'(mem[16'h0035]), 32'h71);
        chk("t1_x", 32'(dut.x), 32'h90);
        chk("t1_a", 32'(dut.a), 32'h71);
        chk("t1_ab0", 32'(hist[0]), 32'h0000);
        chk("t1_ab1", 32'(hist[1]), 32'h0001);
        chk("t1_ab2", 32'(hist[2]), 32'h0002);
        chk("t1_ab3", 32'(hist[3]), 32'h0400);
        chk("t1_ab4", 32'(hist[4]), 32'h0003);

        // Immediate loads with absolute stores
        hold_reset();
        prog = '{8'hA9, 8'h27, 8'h8D, 8'h11, 8'h00, 8'hA2, 8'h21, 8'h8E, 8'h16, 8'h00,
                 8'hA0, 8'h47, 8'h8C, 8'h17, 8'h00};
        load_prog(prog);
        go();
        run(18);
        end_check("t2");
        chk("t2_mem0011", 32'(mem[16'h0011]), 32'h27);
        chk("t2_mem0016", 32'(mem[16'h0016]), 32'h21);
        chk("t2_mem0017", 32'(mem[16'h0017]), 32'h47);
        chk("t2_we_pulses", 32'(we_cnt), 32'd3);

        // Flags
        hold_reset();
        prog = '{8'hA9, 8'h00, 8'hA9, 8'h80, 8'h85, 8'h50};
        load_prog(prog);
        go();
        run(2);
        chk("t3_z_after_00", 32'(dut.flag_z), 32'h1);
        chk("t3_n_after_00", 32'(dut.flag_n), 32'h0);
        run(2);
        chk("t3_z_after_80", 32'(dut.flag_z), 32'h0);
        chk("t3_n_after_80", 32'(dut.flag_n), 32'h1);
        run(3);
        chk("t3_z_after_sta", 32'(dut.flag_z), 32'h0);
        chk("t3_n_after_sta", 32'(dut.flag_n), 32'h1);
        chk("t3_mem0050", 32'(mem[16'h0050]), 32'h80);
        end_check("t3");

        // Undefined opcodes
        hold_reset();
        prog = '{8'h03, 8'h09, 8'hA9, 8'h05};
        load_prog(prog);
        go();
        run(6);
        end_check("t4");
        chk("t4_a", 32'(dut.a), 32'h05);
        chk("t4_no_writes", 32'(we_cnt), 32'd0);
        chk("t4_ab0", 32'(hist[0]), 32'h0000);
        chk("t4_ab1", 32'(hist[1]), 32'h0001);
        chk("t4_ab2", 32'(hist[2]), 32'h0001);
        chk("t4_ab3", 32'(hist[3]), 32'h0002);
        chk("t4_ab4", 32'(hist[4]), 32'h0002);
        chk("t4_ab5", 32'(hist[5]), 32'h0003);

        // Reset during the EX cycle of a store
        hold_reset();
        poke(16'h0020, 8'h33);
        prog = '{8'hA9, 8'h5A, 8'h8D, 8'h20, 8'h00};
        load_prog(prog);
        go();
        run(5);
        chk("t5_we_in_ex", 32'(bus.we), 32'h1);
        chk("t5_ab_in_ex", 32'(bus.ab), 32'h0020);
        chk("t5_do_in_ex", 32'(bus.dout), 32'h5A);
        chk_en = 1'b0;
        reset  = 1'b0;
        #1;
        chk("t5_we_reset", 32'(bus.we), 32'h0);
        chk("t5_ab_reset", 32'(bus.ab), 32'h0000);
        run(2);
        chk("t5_mem_kept", 32'(mem[16'h0020]), 32'h33);
        mm[16'h0020] = 8'h33;  // the model had already committed the aborted store
        go();
        run(2);
        chk("t5_restart_ab0", 32'(hist[0]), 32'h0000);
        chk("t5_restart_ab1", 32'(hist[1]), 32'h0001);
        chk("t5_restart_a", 32'(dut.a), 32'h5A);
        end_check("t5");

        // PC wrap: NOP at 0000, LDA #00 pairs up to FFFE, then A9 at FFFF with operand 11 at 0000
        hold_reset();
        poke(16'h0000, 8'h11);
        for (int i = 1; i < 65535; i += 2) begin
            poke(16'(i), 8'hA9);
            poke(16'(i + 1), 8'h00);
        end
        poke(16'hFFFF, 8'hA9);
        go();
        run(65536);
        chk("t6_fetch_ffff", 32'(bus.ab), 32'hFFFF);
        chk("t6_a_before", 32'(dut.a), 32'h00);
        run(1);
        chk("t6_wrap_0000", 32'(bus.ab), 32'h0000);
        run(1);
        chk("t6_a", 32'(dut.a), 32'h11);
        chk("t6_next_fetch", 32'(bus.ab), 32'h0001);
        end_check("t6");

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
